// File: rtl/ram_scan.sv
// Inferred RAM exerciser with manual, auto-scan and bulk-fill modes plus seven-segment encoders.
// Read data lags cur_addr by one clock; no backpressure, fill runs 2^ADDR_W clocks and ignores mode/step.
module ram_scan #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic                           step,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              addr_in,
  input  logic [DATA_W-1:0]              data_in,
  output logic [ADDR_W-1:0]              cur_addr,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           paused,
  output logic [7*((ADDR_W+3)/4)-1:0]    hex_addr,
  output logic [7*((DATA_W+3)/4)-1:0]    hex_data
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int ADDR_DIG = (ADDR_W + 3) / 4;
  localparam int DATA_DIG = (DATA_W + 3) / 4;
  localparam int ADDR_PW  = 4 * ADDR_DIG;
  localparam int DATA_PW  = 4 * DATA_DIG;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_FILL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_step_q;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_busy;
  logic                r_done;
  logic                r_paused;
  logic [TICK_W-1:0]   r_tick;
  logic [ADDR_W-1:0]   r_index;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_step_rise;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdat;
  logic [ADDR_PW-1:0]  w_addr_pad;
  logic [DATA_PW-1:0]  w_data_pad;

  assign w_step_rise = step & ~r_step_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_MANUAL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = addr_in;
    w_wdat      = data_in;
    case (r_state)
      ST_MANUAL: begin
        if (mode == 2'b01)                     w_state_nxt = ST_SCAN;
        else if (mode == 2'b10 && w_step_rise) w_state_nxt = ST_FILL;
        else if (w_step_rise && wr_en)         w_we = 1'b1;
      end
      ST_SCAN: begin
        if (mode != 2'b01) w_state_nxt = ST_MANUAL;
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_waddr = r_index;
        w_wdat  = data_in + DATA_W'(r_index);
        if (r_index == LAST_IDX) w_state_nxt = ST_MANUAL;
      end
      default: w_state_nxt = ST_MANUAL;
    endcase
  end

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step_q   <= 1'b0;
      r_cur_addr <= '0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_paused   <= 1'b0;
      r_tick     <= '0;
      r_index    <= '0;
    end else begin
      r_step_q  <= step;
      r_rd_data <= r_mem[r_cur_addr];
      r_done    <= 1'b0;
      case (r_state)
        ST_MANUAL: begin
          r_cur_addr <= addr_in;
          if (w_state_nxt == ST_SCAN) begin
            r_tick   <= '0;
            r_paused <= 1'b0;
          end else if (w_state_nxt == ST_FILL) begin
            r_index    <= '0;
            r_busy     <= 1'b1;
            r_cur_addr <= '0;
          end
        end
        ST_SCAN: begin
          if (w_state_nxt == ST_MANUAL) begin
            r_paused   <= 1'b0;
            r_cur_addr <= addr_in;
          end else begin
            if (w_step_rise) r_paused <= ~r_paused;
            if (!r_paused) begin
              if (r_tick == TICK_MAX) begin
                r_tick     <= '0;
                r_cur_addr <= r_cur_addr + 1'b1;
              end else begin
                r_tick <= r_tick + 1'b1;
              end
            end
          end
        end
        ST_FILL: begin
          // cur_addr tracks the index being written on the next edge.
          r_index    <= r_index + 1'b1;
          r_cur_addr <= r_index + 1'b1;
          if (r_index == LAST_IDX) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'b0000001;
      4'h1: f_seg = 7'b1001111;
      4'h2: f_seg = 7'b0010010;
      4'h3: f_seg = 7'b0000110;
      4'h4: f_seg = 7'b1001100;
      4'h5: f_seg = 7'b0100100;
      4'h6: f_seg = 7'b0100000;
      4'h7: f_seg = 7'b0001111;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0001100;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b1100000;
      4'hC: f_seg = 7'b0110001;
      4'hD: f_seg = 7'b1000010;
      4'hE: f_seg = 7'b0110000;
      default: f_seg = 7'b0111000;
    endcase
  endfunction

  assign w_addr_pad = ADDR_PW'(r_cur_addr);
  assign w_data_pad = DATA_PW'(r_rd_data);

  for (genvar g = 0; g < ADDR_DIG; g++) begin : g_hex_addr
    assign hex_addr[7*g +: 7] = f_seg(w_addr_pad[4*g +: 4]);
  end
  for (genvar g = 0; g < DATA_DIG; g++) begin : g_hex_data
    assign hex_data[7*g +: 7] = f_seg(w_data_pad[4*g +: 4]);
  end

  assign cur_addr = r_cur_addr;
  assign rd_data  = r_rd_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign paused   = r_paused;

endmodule
